// File: rtl/chs_conf_encoder_pkg.sv
// ----------------------------------------------------------------------------
// chs_pkg
// Shared widths, limits and the encoder FSM state type used by the
// configuration encoder, its shift register and its testbench.
// ----------------------------------------------------------------------------
package chs_pkg;

    localparam int CONF_W    = 8;
    localparam int POWER_W   = 4;
    localparam int MAX_POWER = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        DONE  = 2'd2
    } chs_state_e;

    // Power level actually encoded: requests above MAX_POWER saturate.
    function automatic logic [POWER_W-1:0] clamp_power(input logic [POWER_W-1:0] pw);
        return (pw > POWER_W'(MAX_POWER)) ? POWER_W'(MAX_POWER) : pw;
    endfunction

endpackage

// File: rtl/chs_conf_encoder_if.sv
// ----------------------------------------------------------------------------
// chs_conf_encoder_if
// Request and configuration channels of the encoder.
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both 1. Request side: req_power/req_mode/req_pack
// are sampled on that edge. Configuration side: chs_conf/chs_err are held
// stable while conf_valid=1 until the transfer edge.
//
//   req_valid  m->s  request present
//   req_ready  s->m  encoder idle, can accept
//   req_power  m->s  requested number of 1 bits (4 bits)
//   req_mode   m->s  heat=1 / cool=0
//   req_pack   m->s  0 = ones at LSBs, 1 = ones at MSBs
//   conf_valid s->m  chs_conf/chs_err valid
//   conf_ready m->s  consumer accepts configuration
//   chs_conf   s->m  configuration word (8 bits)
//   chs_err    s->m  bit0 power clamped, bit1 mode mismatch
// ----------------------------------------------------------------------------
interface chs_conf_encoder_if;
    import chs_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic [POWER_W-1:0]   req_power;
    logic                 req_mode;
    logic                 req_pack;
    logic                 conf_valid;
    logic                 conf_ready;
    logic [CONF_W-1:0]    chs_conf;
    logic [1:0]           chs_err;

    modport slave (
        input  req_valid, req_power, req_mode, req_pack, conf_ready,
        output req_ready, conf_valid, chs_conf, chs_err
    );

    modport master (
        output req_valid, req_power, req_mode, req_pack, conf_ready,
        input  req_ready, conf_valid, chs_conf, chs_err
    );

endinterface

// File: rtl/chs_conf_encoder_shreg.sv
// ----------------------------------------------------------------------------
// chs_conf_shreg
// 8-bit left-shifting register with synchronous clear, shift enable and
// serial input entering at the LSB. Clear has priority over shift.
//
//   clk        clock
//   rst_n      asynchronous active-low reset (register -> 0)
//   clr_i      clear to zero on next edge
//   shift_en_i shift left by one, ser_i enters bit 0
//   ser_i      serial data in
//   q_o        register contents
// ----------------------------------------------------------------------------
module chs_conf_shreg
    import chs_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              shift_en_i,
    input  logic              ser_i,
    output logic [CONF_W-1:0] q_o
);

    logic [CONF_W-1:0] shreg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
        end else if (clr_i) begin
            shreg_q <= '0;
        end else if (shift_en_i) begin
            shreg_q <= {shreg_q[CONF_W-2:0], ser_i};
        end
    end

    assign q_o = shreg_q;

endmodule

// File: rtl/chs_conf_encoder.sv
// ----------------------------------------------------------------------------
// chs_conf_encoder
// Accepts a power/mode/pack request, then serially builds a thermometer-coded
// configuration word over 8 cycles and presents it until the consumer takes it.
//
//   clk      clock, rising edge
//   rst_n    asynchronous active-low reset
//   bus      chs_conf_encoder_if.slave (request + configuration channels)
//   state_o  current FSM state, for observation
// ----------------------------------------------------------------------------
module chs_conf_encoder
    import chs_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    chs_conf_encoder_if.slave     bus,
    output chs_state_e            state_o
);

    chs_state_e           state_q, state_d;
    logic [2:0]           step_q, step_d;
    logic [POWER_W-1:0]   power_q, power_d;
    logic                 pack_q, pack_d;
    logic [1:0]           err_q, err_d;

    logic                 sh_clr;
    logic                 sh_en;
    logic                 sh_ser;
    logic [POWER_W-1:0]   req_p;

    assign req_p = clamp_power(bus.req_power);

    // The bit shifted in at step s ends up at position 7-s. So for LSB packing
    // the last P steps carry ones, for MSB packing the first P steps do.
    always_comb begin
        if (pack_q) begin
            sh_ser = ({1'b0, step_q} < power_q);
        end else begin
            sh_ser = ({1'b0, step_q} >= (POWER_W'(MAX_POWER) - power_q));
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        power_d = power_q;
        pack_d  = pack_q;
        err_d   = err_q;
        sh_clr  = 1'b0;
        sh_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d = BUILD;
                    step_d  = 3'd0;
                    power_d = req_p;
                    pack_d  = bus.req_pack;
                    err_d   = {bus.req_mode != req_p[0], bus.req_power > POWER_W'(MAX_POWER)};
                    sh_clr  = 1'b1;
                end
            end
            BUILD: begin
                sh_en = 1'b1;
                if (step_q == 3'd7) begin
                    state_d = DONE;
                    step_d  = 3'd0;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            DONE: begin
                if (bus.conf_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= 3'd0;
            power_q <= '0;
            pack_q  <= 1'b0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            power_q <= power_d;
            pack_q  <= pack_d;
            err_q   <= err_d;
        end
    end

    chs_conf_shreg u_shreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (sh_clr),
        .shift_en_i (sh_en),
        .ser_i      (sh_ser),
        .q_o        (bus.chs_conf)
    );

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.conf_valid = (state_q == DONE);
    assign bus.chs_err    = err_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_chs_conf_encoder.sv
module tb_chs_conf_encoder;
  import chs_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  chs_state_e state_dbg;

  chs_conf_encoder_if bus ();

  chs_conf_encoder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  // entry = {P[3:0], err[1:0], conf[7:0]}
  logic [13:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: P = min(power, 8); conf is P ones at the LSB or MSB end.
  function automatic logic [13:0] model(input logic [3:0] pw, input logic md, input logic pk);
    int p;
    int c;
    logic [3:0] p4;
    logic [1:0] e;
    p = (pw > 8) ? 8 : int'(pw);
    if (pk) c = (255 << (8 - p)) & 255;
    else    c = (1 << p) - 1;
    p4 = 4'(p);
    e = {md != p4[0], pw > 4'd8};
    return {p4, e, 8'(c)};
  endfunction

  // Compare process: every cycle the output is valid it must match the head.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("ready_and_valid_exclusive", {31'd0, bus.req_ready & bus.conf_valid}, 32'd0);
      if (bus.conf_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_conf_valid: got conf 0x%0h required no output", bus.chs_conf);
        end else begin
          check("sb_conf", {24'd0, bus.chs_conf}, {24'd0, exp_q[0][7:0]});
          check("sb_err", {30'd0, bus.chs_err}, {30'd0, exp_q[0][9:8]});
          check("sb_popcount", $countones(bus.chs_conf), {28'd0, exp_q[0][13:10]});
          check("sb_parity", {31'd0, ^bus.chs_conf}, {31'd0, exp_q[0][10]});
          if (bus.conf_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1. Returns at posedge+1 just after conf_valid rises.
  task automatic send(input logic [3:0] pw, input logic md, input logic pk);
    int guard = 0;
    logic early = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_power = pw;
    bus.req_mode  = md;
    bus.req_pack  = pk;
    while (bus.req_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got req_ready=%b required 1", bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(model(pw, md, pk));
    #1;
    // scramble inputs after accept: they must have no effect
    bus.req_valid = 1'b0;
    bus.req_power = 4'($urandom_range(0, 15));
    bus.req_mode  = 1'($urandom_range(0, 1));
    bus.req_pack  = 1'($urandom_range(0, 1));
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (bus.conf_valid !== 1'b0) early = 1'b1;
    end
    @(posedge clk); #1;
    check("latency_no_early_valid", {31'd0, early}, 32'd0);
    check("latency_valid_at_8", {31'd0, bus.conf_valid}, 32'd1);
  endtask

  task automatic drain(input int d);
    bus.conf_ready = 1'b0;
    for (int k = 0; k < d; k++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'd0, bus.conf_valid}, 32'd1);
    end
    bus.conf_ready = 1'b1;
    @(posedge clk); #1;
    bus.conf_ready = 1'b0;
    check("after_drain_valid", {31'd0, bus.conf_valid}, 32'd0);
    check("after_drain_ready", {31'd0, bus.req_ready}, 32'd1);
  endtask

  task automatic directed(input logic [3:0] pw, input logic md, input logic pk,
                          input logic [7:0] c, input logic [1:0] e, input string name);
    send(pw, md, pk);
    check({name, "_conf"}, {24'd0, bus.chs_conf}, {24'd0, c});
    check({name, "_err"}, {30'd0, bus.chs_err}, {30'd0, e});
    drain(1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic quiet;
    bus.req_valid  = 1'b0;
    bus.req_power  = 4'd0;
    bus.req_mode   = 1'b0;
    bus.req_pack   = 1'b0;
    bus.conf_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    check("rst_conf", {24'd0, bus.chs_conf}, 32'd0);
    check("rst_err", {30'd0, bus.chs_err}, 32'd0);
    check("rst_valid", {31'd0, bus.conf_valid}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, {30'd0, IDLE});
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);

    directed(4'd3,  1'b1, 1'b0, 8'h07, 2'b00, "p3_lsb");
    directed(4'd5,  1'b0, 1'b1, 8'hF8, 2'b10, "p5_msb");
    directed(4'd12, 1'b0, 1'b0, 8'hFF, 2'b01, "p12_clamp");
    directed(4'd0,  1'b0, 1'b1, 8'h00, 2'b00, "p0_msb");
    directed(4'd8,  1'b1, 1'b1, 8'hFF, 2'b10, "p8_msb");

    // backpressure in DONE with a competing request that must be ignored
    send(4'd4, 1'b0, 1'b0);
    bus.req_valid  = 1'b1;
    bus.req_power  = 4'd9;
    bus.conf_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("bp_valid", {31'd0, bus.conf_valid}, 32'd1);
      check("bp_conf", {24'd0, bus.chs_conf}, 32'h0F);
      check("bp_err", {30'd0, bus.chs_err}, 32'd0);
      check("bp_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    bus.req_valid  = 1'b0;
    bus.conf_ready = 1'b1;
    @(posedge clk); #1;
    bus.conf_ready = 1'b0;
    check("bp_idle_state", {30'd0, state_dbg}, {30'd0, IDLE});
    check("bp_idle_valid", {31'd0, bus.conf_valid}, 32'd0);
    check("bp_idle_conf_held", {24'd0, bus.chs_conf}, 32'h0F);
    @(posedge clk); #1;
    check("bp_no_stray_accept", {31'd0, bus.req_ready}, 32'd1);

    // reset in the middle of BUILD
    bus.req_valid = 1'b1;
    bus.req_power = 4'd6;
    bus.req_mode  = 1'b0;
    bus.req_pack  = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_state", {30'd0, state_dbg}, {30'd0, IDLE});
    check("mid_rst_conf", {24'd0, bus.chs_conf}, 32'd0);
    check("mid_rst_err", {30'd0, bus.chs_err}, 32'd0);
    check("mid_rst_valid", {31'd0, bus.conf_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus.conf_valid !== 1'b0) quiet = 1'b0;
    end
    check("mid_rst_no_pulse", {31'd0, quiet}, 32'd1);
    directed(4'd2, 1'b0, 1'b0, 8'h03, 2'b00, "p2_after_rst");

    // randomized traffic against the model
    for (int t = 0; t < 40; t++) begin
      send(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drain($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    @(posedge clk); #1;
    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
